// File: rtl/regs_wb_sched_pkg.sv
// Shared constants for the writeback scheduler: zero-register index and requester encoding.
package regs_wb_sched_pkg;

    // Register index that is hardwired to zero and never tracked.
    localparam int unsigned ZERO_REG = 0;

    // Requester indices; also the values held by the round-robin pointer.
    localparam logic REQ_EX = 1'b0;
    localparam logic REQ_LD = 1'b1;

endpackage

// File: rtl/regs_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered preference pointer.
module regs_wb_sched_rr_arb2
    import regs_wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    // Grant the sole requester, or the preferred one under contention; then prefer the loser.
    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        unique case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (ptr_q == REQ_EX) begin
                    grant = 2'b01;
                    ptr_d = REQ_LD;
                end else begin
                    grant = 2'b10;
                    ptr_d = REQ_EX;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Pointer register; reset prefers the execute requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_EX;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regs_wb_sched.sv
// Writeback scheduler and scoreboard in front of a 1W/2R register file with x0 hardwired to zero.
module regs_wb_sched
    import regs_wb_sched_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NR_REGS    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic                  rsv_ready,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_data,
    output logic                  req1_ready,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] addrw,
    output logic [WIDTH-1:0]      dinw,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic                  hazard_a,
    output logic                  hazard_b
);

    logic [NR_REGS-1:0]    pending_q, pending_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addrw_q, addrw_d;
    logic [WIDTH-1:0]      dinw_q, dinw_d;
    logic [1:0]            grant;

    regs_wb_sched_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // A still-pending destination (including one releasing this cycle) blocks re-reservation.
    always_comb begin
        rsv_ready = !pending_q[rsv_addr] && !flush;
        hazard_a  = pending_q[addra];
        hazard_b  = pending_q[addrb];
    end

    // Scoreboard next state: release on write, set on reservation, flush clears everything.
    always_comb begin
        pending_d = pending_q;
        if (wen_q) begin
            pending_d[addrw_q] = 1'b0;
        end
        if (rsv_valid && rsv_ready) begin
            pending_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
        pending_d[ZERO_REG] = 1'b0;
    end

    // Output stage: capture the granted request; a write to x0 is accepted but suppressed.
    always_comb begin
        wen_d   = 1'b0;
        addrw_d = addrw_q;
        dinw_d  = dinw_q;
        if (grant[0]) begin
            wen_d   = (req0_addr != ADDR_WIDTH'(ZERO_REG));
            addrw_d = req0_addr;
            dinw_d  = req0_data;
        end else if (grant[1]) begin
            wen_d   = (req1_addr != ADDR_WIDTH'(ZERO_REG));
            addrw_d = req1_addr;
            dinw_d  = req1_data;
        end
    end

    // State registers; reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            wen_q     <= 1'b0;
            addrw_q   <= '0;
            dinw_q    <= '0;
        end else begin
            pending_q <= pending_d;
            wen_q     <= wen_d;
            addrw_q   <= addrw_d;
            dinw_q    <= dinw_d;
        end
    end

    assign wen   = wen_q;
    assign addrw = addrw_q;
    assign dinw  = dinw_q;

endmodule
